// File: rtl/note_scroller.sv
`default_nettype none
// ============================================================================
// Module   : note_scroller
// Brief    : Six-lane note bitmap scroller with valid/ready note intake,
//            per-lane miss pulses and an optional pause input
//            (NOTE_SCROLLER_PAUSE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module note_scroller #(
    parameter int ROWS     = 480,
    parameter int TICK_DIV = 250000,
    parameter int NOTE_LEN = 20,
    parameter int NOTE_GAP = 4
) (
    input  logic            OriginalClk,
    input  logic            Reset,
    input  logic            Clear,
`ifdef NOTE_SCROLLER_PAUSE_EN
    input  logic            Pause,
`endif
    input  logic            NoteValid,
    input  logic [5:0]      NoteLanes,
    output logic            NoteReady,
    output logic [ROWS-1:0] track1_data,
    output logic [ROWS-1:0] track2_data,
    output logic [ROWS-1:0] track3_data,
    output logic [ROWS-1:0] track4_data,
    output logic [ROWS-1:0] track5_data,
    output logic [ROWS-1:0] track6_data,
    output logic [5:0]      Miss,
    output logic            StepPulse
);

    localparam int c_TICK_W  = $clog2(TICK_DIV);
    localparam int c_CNT_MAX = (NOTE_LEN > NOTE_GAP) ? NOTE_LEN : NOTE_GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LEN   = c_CNT_W'(NOTE_LEN);
    localparam logic [c_CNT_W-1:0]  c_CNT_GAP   = c_CNT_W'(NOTE_GAP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PAINT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [5:0]          r_mask;
    logic [c_TICK_W-1:0] r_tick;
    logic [ROWS-1:0]     r_track [6];
    logic [5:0]          r_miss;
    logic                r_step_pulse;
    logic                w_pause;
    logic                w_step;
    logic [5:0]          w_inj;

`ifdef NOTE_SCROLLER_PAUSE_EN
    assign w_pause = Pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_step    = !w_pause && (r_tick == c_TICK_LAST);
    assign w_inj     = (r_state == S_PAINT) ? r_mask : 6'd0;
    assign NoteReady = (r_state == S_IDLE);

    always_ff @(posedge OriginalClk or posedge Reset) begin
        if (Reset) begin
            r_tick       <= '0;
            r_step_pulse <= 1'b0;
        end else if (Clear) begin
            r_tick       <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_pulse <= w_step;
            if (!w_pause)
                r_tick <= (r_tick == c_TICK_LAST) ? '0 : r_tick + 1'b1;
        end
    end

    // Accept only happens in IDLE, so a coincident step still sees IDLE and injects 0.
    always_ff @(posedge OriginalClk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else if (Clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (NoteValid) begin
                        r_mask  <= NoteLanes;
                        r_cnt   <= c_CNT_LEN;
                        r_state <= S_PAINT;
                    end
                end
                S_PAINT: begin
                    if (w_step) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_CNT_ONE) begin
                            r_cnt   <= c_CNT_GAP;
                            r_state <= (NOTE_GAP == 0) ? S_IDLE : S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (w_step) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_CNT_ONE)
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A miss marks the trailing row of a note: bottom row set, row above it empty.
    always_ff @(posedge OriginalClk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 6; i++)
                r_track[i] <= '0;
            r_miss <= '0;
        end else if (Clear) begin
            for (int i = 0; i < 6; i++)
                r_track[i] <= '0;
            r_miss <= '0;
        end else if (w_step) begin
            for (int i = 0; i < 6; i++) begin
                r_track[i] <= {r_track[i][ROWS-2:0], w_inj[i]};
                r_miss[i]  <= r_track[i][ROWS-1] & ~r_track[i][ROWS-2];
            end
        end else begin
            r_miss <= '0;
        end
    end

    assign track1_data = r_track[0];
    assign track2_data = r_track[1];
    assign track3_data = r_track[2];
    assign track4_data = r_track[3];
    assign track5_data = r_track[4];
    assign track6_data = r_track[5];
    assign Miss        = r_miss;
    assign StepPulse   = r_step_pulse;

endmodule
`default_nettype wire
